// File: rtl/seq_det_pkg.sv
// Shared constants, state type and parameter checks for the serial
// pattern detector family.
package seq_det_pkg;

    localparam logic MODE_NONOVL = 1'b0;
    localparam logic MODE_OVL    = 1'b1;

    typedef enum logic {
        ST_FILLING = 1'b0,
        ST_ARMED   = 1'b1
    } det_state_e;

    function automatic bit pat_w_legal(input int w);
        return (w >= 2) && (w <= 32);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               clr,
    input  logic               inc,
    output logic [COUNT_W-1:0] count
);

    logic [COUNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {COUNT_W{1'b1}})) begin
            count_reg <= count_reg + COUNT_W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/seq_pattern_det.sv
// Run-time programmable serial pattern detector with don't-care mask,
// overlap / non-overlap modes, registered match pulse and match counter.
module seq_pattern_det
    import seq_det_pkg::*;
#(
    parameter int PAT_W   = 3,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               cfg_load,
    input  logic [PAT_W-1:0]   cfg_pattern,
    input  logic [PAT_W-1:0]   cfg_mask,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               in,
    input  logic               cnt_clr,
    output logic               out,
    output logic [COUNT_W-1:0] match_cnt,
    output logic               hist_full
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

    if (!pat_w_legal(PAT_W)) begin : g_bad_pat_w
        $error("seq_pattern_det: PAT_W must be in 2..32");
    end

    logic [PAT_W-1:0]  pat_q;
    logic [PAT_W-1:0]  mask_q;
    logic              ovl_q;
    logic [PAT_W-1:0]  hist_reg, hist_next;
    logic [FILL_W-1:0] fill_reg, fill_next;
    logic              out_reg, out_next;
    logic              match;
    logic [PAT_W-1:0]  shifted;
    logic [FILL_W-1:0] fill_inc;
    det_state_e        state;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pat_q    <= '0;
            mask_q   <= '1;
            ovl_q    <= MODE_OVL;
            hist_reg <= '0;
            fill_reg <= '0;
            out_reg  <= 1'b0;
        end else begin
            if (cfg_load) begin
                pat_q  <= cfg_pattern;
                mask_q <= cfg_mask;
                ovl_q  <= cfg_overlap;
            end
            hist_reg <= hist_next;
            fill_reg <= fill_next;
            out_reg  <= out_next;
        end
    end

    always_comb begin
        hist_next = hist_reg;
        fill_next = fill_reg;
        out_next  = 1'b0;
        match     = 1'b0;
        shifted   = {hist_reg[PAT_W-2:0], in};
        fill_inc  = (fill_reg == FILL_MAX) ? fill_reg : fill_reg + FILL_W'(1);

        if (cfg_load) begin
            // A bit arriving with a config load is discarded along with the history.
            hist_next = '0;
            fill_next = '0;
        end else if (in_valid) begin
            match    = (fill_inc == FILL_MAX) && (((shifted ^ pat_q) & mask_q) == '0);
            out_next = match;
            if (match && (ovl_q == MODE_NONOVL)) begin
                hist_next = '0;
                fill_next = '0;
            end else begin
                hist_next = shifted;
                fill_next = fill_inc;
            end
        end
    end

    assign state     = (fill_reg == FILL_MAX) ? ST_ARMED : ST_FILLING;
    assign hist_full = (state == ST_ARMED);
    assign out       = out_reg;

    sat_counter #(
        .COUNT_W(COUNT_W)
    ) u_match_cnt (
        .clk  (clk),
        .rstn (rstn),
        .clr  (cnt_clr),
        .inc  (match),
        .count(match_cnt)
    );

endmodule

// File: tb/tb_seq_pattern_det.sv
// Bench for seq_pattern_det: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_seq_pattern_det;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       cfg_load = 1'b0;
    logic [2:0] cfg_pattern = '0;
    logic [2:0] cfg_mask = '0;
    logic       cfg_overlap = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       cnt_clr = 1'b0;

    logic       out_a, out_b, full_a, full_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int n_vec = 0;
    int n_fail = 0;

    // Reference model: the valid bits received since the last flush.
    bit       q[$];
    bit [2:0] m_pat = '0;
    bit [2:0] m_mask = '1;
    bit       m_ovl = 1'b1;
    bit       m_out = 1'b0;
    int       m_cnt8 = 0;
    int       m_cnt2 = 0;

    always #5 clk = ~clk;

    seq_pattern_det #(.PAT_W(3), .COUNT_W(8)) dut_a (
        .clk(clk), .rstn(rstn), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_mask(cfg_mask), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
        .in(in_bit), .cnt_clr(cnt_clr), .out(out_a), .match_cnt(cnt_a),
        .hist_full(full_a)
    );

    seq_pattern_det #(.PAT_W(3), .COUNT_W(2)) dut_b (
        .clk(clk), .rstn(rstn), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_mask(cfg_mask), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
        .in(in_bit), .cnt_clr(cnt_clr), .out(out_b), .match_cnt(cnt_b),
        .hist_full(full_b)
    );

    typedef struct {
        logic       rstn;
        logic       ld;
        logic [2:0] pat;
        logic [2:0] mask;
        logic       ovl;
        logic       iv;
        logic       b;
        logic       clr;
        logic       exp_out;
        int         exp_cnt;
        logic       exp_full;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_edge(input bit r, input bit ld, input bit [2:0] p,
                                       input bit [2:0] mk, input bit ov, input bit iv,
                                       input bit b, input bit clr);
        bit m;
        m = 1'b0;
        if (!r) begin
            q.delete();
            m_pat = '0; m_mask = '1; m_ovl = 1'b1;
            m_out = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
            return;
        end
        if (ld) begin
            m_pat = p; m_mask = mk; m_ovl = ov;
            q.delete();
        end else if (iv) begin
            q.push_back(b);
            if (q.size() > 3) void'(q.pop_front());
            if (q.size() == 3) begin
                m = 1'b1;
                // Oldest bit in the window lines up with pattern bit 2.
                for (int i = 0; i < 3; i++)
                    if (m_mask[2-i] && (q[i] != m_pat[2-i])) m = 1'b0;
            end
            if (m && !m_ovl) q.delete();
        end
        m_out = m;
        if (clr) begin
            m_cnt8 = 0; m_cnt2 = 0;
        end else if (m) begin
            m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
            m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
        end
    endfunction

    // Drive one cycle of inputs, clock it, and leave time 1 unit past the edge.
    task automatic apply(input bit r, input bit ld, input bit [2:0] p, input bit [2:0] mk,
                         input bit ov, input bit iv, input bit b, input bit clr);
        rstn = r; cfg_load = ld; cfg_pattern = p; cfg_mask = mk; cfg_overlap = ov;
        in_valid = iv; in_bit = b; cnt_clr = clr;
        @(posedge clk);
        model_edge(r, ld, p, mk, ov, iv, b, clr);
        #1;
    endtask

    task automatic bit_in(input bit b);
        apply(1, 0, 3'b000, 3'b000, 0, 1, b, 0);
    endtask

    task automatic load(input bit [2:0] p, input bit [2:0] mk, input bit ov);
        apply(1, 1, p, mk, ov, 0, 0, 0);
    endtask

    vec_t tbl[$];

    function automatic vec_t mk_ld(input logic [2:0] p, input logic [2:0] mk, input logic ov,
                                   input int c);
        vec_t v;
        v = '{1, 1, p, mk, ov, 0, 0, 0, 0, c, 0};
        return v;
    endfunction

    function automatic vec_t mk_bit(input logic b, input logic eo, input int c, input logic f);
        vec_t v;
        v = '{1, 0, 3'b000, 3'b000, 0, 1, b, 0, eo, c, f};
        return v;
    endfunction

    function automatic vec_t mk_clr(input logic f);
        vec_t v;
        v = '{1, 0, 3'b000, 3'b000, 0, 0, 0, 1, 0, 0, f};
        return v;
    endfunction

    initial begin
        // Reset state
        tbl.push_back('{0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0});
        // Pattern 110, overlap: 1,1,1,0,0 -> one pulse after bit 4
        tbl.push_back(mk_ld(3'b110, 3'b111, 1, 0));
        tbl.push_back(mk_bit(1, 0, 0, 0));
        tbl.push_back(mk_bit(1, 0, 0, 0));
        tbl.push_back(mk_bit(1, 0, 0, 1));
        tbl.push_back(mk_bit(0, 1, 1, 1));
        tbl.push_back(mk_bit(0, 0, 1, 1));
        tbl.push_back(mk_clr(1));
        // Pattern 101 overlap: pulses after bits 3 and 5
        tbl.push_back(mk_ld(3'b101, 3'b111, 1, 0));
        tbl.push_back(mk_bit(1, 0, 0, 0));
        tbl.push_back(mk_bit(0, 0, 0, 0));
        tbl.push_back(mk_bit(1, 1, 1, 1));
        tbl.push_back(mk_bit(0, 0, 1, 1));
        tbl.push_back(mk_bit(1, 1, 2, 1));
        tbl.push_back(mk_clr(1));
        // Pattern 101 non-overlap: single pulse after bit 3
        tbl.push_back(mk_ld(3'b101, 3'b111, 0, 0));
        tbl.push_back(mk_bit(1, 0, 0, 0));
        tbl.push_back(mk_bit(0, 0, 0, 0));
        tbl.push_back(mk_bit(1, 1, 1, 0));
        tbl.push_back(mk_bit(0, 0, 1, 0));
        tbl.push_back(mk_bit(1, 0, 1, 0));
        tbl.push_back(mk_clr(0));
        // Mask 101, pattern 100: 100 and 110 match, 010 does not
        tbl.push_back(mk_ld(3'b100, 3'b101, 0, 0));
        tbl.push_back(mk_bit(1, 0, 0, 0));
        tbl.push_back(mk_bit(0, 0, 0, 0));
        tbl.push_back(mk_bit(0, 1, 1, 0));
        tbl.push_back(mk_bit(1, 0, 1, 0));
        tbl.push_back(mk_bit(1, 0, 1, 0));
        tbl.push_back(mk_bit(0, 1, 2, 0));
        tbl.push_back(mk_bit(0, 0, 2, 0));
        tbl.push_back(mk_bit(1, 0, 2, 0));
        tbl.push_back(mk_bit(0, 0, 2, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].rstn, tbl[i].ld, tbl[i].pat, tbl[i].mask, tbl[i].ovl,
                  tbl[i].iv, tbl[i].b, tbl[i].clr);
            chk($sformatf("tbl%0d_out", i), int'(out_a), int'(tbl[i].exp_out));
            chk($sformatf("tbl%0d_cnt", i), int'(cnt_a), tbl[i].exp_cnt);
            chk($sformatf("tbl%0d_full", i), int'(full_a), int'(tbl[i].exp_full));
            chk($sformatf("tbl%0d_cnt2", i), int'(cnt_b), m_cnt2);
        end

        // Sparse valid: 1,1,0 with 4 idle cycles before each bit
        load(3'b110, 3'b111, 1);
        apply(1, 0, 3'b000, 3'b000, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++) begin
                apply(1, 0, 3'b000, 3'b000, 0, 0, 1'($urandom), 0);
                chk("sparse_idle_out", int'(out_a), 0);
                chk("sparse_idle_full", int'(full_a), (k == 0) ? 0 : int'(k >= 3));
            end
            bit_in((k == 2) ? 1'b0 : 1'b1);
            chk($sformatf("sparse_bit%0d_out", k), int'(out_a), int'(k == 2));
            chk($sformatf("sparse_bit%0d_full", k), int'(full_a), int'(k == 2));
        end
        chk("sparse_cnt", int'(cnt_a), 1);

        // Saturation of the 2-bit counter with pattern 111
        load(3'b111, 3'b111, 1);
        apply(1, 0, 3'b000, 3'b000, 0, 0, 0, 1);
        for (int k = 1; k <= 10; k++) begin
            bit_in(1'b1);
            chk($sformatf("sat_bit%0d_out", k), int'(out_b), int'(k >= 3));
            chk($sformatf("sat_bit%0d_cnt2", k), int'(cnt_b), (k < 3) ? 0 : ((k - 2 > 3) ? 3 : k - 2));
        end
        chk("sat_cnt8", int'(cnt_a), 8);
        apply(1, 0, 3'b000, 3'b000, 0, 1, 1, 1);
        chk("clr_vs_inc_out", int'(out_b), 1);
        chk("clr_vs_inc_cnt2", int'(cnt_b), 0);
        chk("clr_vs_inc_cnt8", int'(cnt_a), 0);

        // Reset in the middle of a stream
        load(3'b110, 3'b111, 1);
        bit_in(1); bit_in(1);
        apply(0, 0, 3'b000, 3'b000, 0, 1, 0, 0);
        chk("midrst_out", int'(out_a), 0);
        chk("midrst_cnt", int'(cnt_a), 0);
        chk("midrst_full", int'(full_a), 0);
        bit_in(0);
        chk("postrst_out", int'(out_a), 0);
        chk("postrst_full", int'(full_a), 0);

        // Config load colliding with the completing bit
        load(3'b110, 3'b111, 1);
        bit_in(1); bit_in(1);
        apply(1, 1, 3'b110, 3'b111, 1, 1, 0, 0);
        chk("ldcoll_out", int'(out_a), 0);
        chk("ldcoll_full", int'(full_a), 0);
        chk("ldcoll_cnt", int'(cnt_a), 0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            bit r, ld, iv, clr, ov;
            bit [2:0] p, mk;
            r   = ($urandom_range(0, 99) != 0);
            ld  = ($urandom_range(0, 29) == 0);
            iv  = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 19) == 0);
            ov  = 1'($urandom);
            p   = 3'($urandom);
            mk  = ($urandom_range(0, 7) == 0) ? 3'b000 : 3'($urandom);
            apply(r, ld, p, mk, ov, iv, 1'($urandom), clr);
            chk("rnd_out", int'(out_a), int'(m_out));
            chk("rnd_cnt8", int'(cnt_a), m_cnt8);
            chk("rnd_cnt2", int'(cnt_b), m_cnt2);
            chk("rnd_full", int'(full_a), int'(q.size() == 3));
            chk("rnd_out_b", int'(out_b), int'(m_out));
            chk("rnd_full_b", int'(full_b), int'(q.size() == 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_pattern_det.md
Name: seq_pattern_det

Overview:
Parametrised serial bit-pattern detector. It is the run-time-programmable successor to the fixed-pattern sequence detectors in the sequential library.
- Matches a PAT_W-bit pattern, with an optional don't-care mask, against a qualified serial bit stream.
- Overlapping or non-overlapping match mode.
- Produces a registered one-cycle match pulse and a saturating match count.
- Used as the front-end framing/sync-word detector for serial receivers.

Parameters:
PAT_W, 3, pattern length in bits (legal range 2..32).
COUNT_W, 8, width of the saturating match counter (legal range 1..32).

Ports:
clk  input  1  system clock; all logic on rising edge.
rstn  input  1  synchronous active-low reset.
cfg_load  input  1  latch cfg_pattern, cfg_mask and cfg_overlap; flush history.
cfg_pattern  input  PAT_W  pattern; bit PAT_W-1 is the first bit received.
cfg_mask  input  PAT_W  1 = compare this bit, 0 = don't care.
cfg_overlap  input  1  1 = overlapping matches, 0 = non-overlapping.
in_valid  input  1  the current in bit is part of the stream.
in  input  1  serial data bit.
cnt_clr  input  1  clear match_cnt.
out  output  1  one-cycle match pulse, registered.
match_cnt  output  COUNT_W  saturating number of matches.
hist_full  output  1  history holds PAT_W valid bits since the last flush.

Behaviour:
- Reset (rstn=0 at a clk edge): pat_q=0, mask_q=all ones, ovl_q=1, hist=0, fill=0, out=0, match_cnt=0, hist_full=0. Reset is applied mid-stream with no residual state, and takes priority over every other input.
- Config: when cfg_load=1, pat_q, mask_q and ovl_q are latched, hist is cleared, fill is cleared and out is cleared next cycle.
  - cfg_load wins over in_valid in the same cycle; that bit is dropped.
  - match_cnt is unaffected by cfg_load.
- Shift: when in_valid=1 and cfg_load=0:
  - hist_n = {hist[PAT_W-2:0], in}
  - fill_n = min(fill+1, PAT_W)
  - When in_valid=0, hist, fill and out hold/clear as follows: hist and fill hold, out goes to 0.
- Match condition: in_valid & ~cfg_load & (fill_n==PAT_W) & (((hist_n ^ pat_q) & mask_q)==0).
- out: registered. It is 1 exactly the cycle after the clock edge that accepted the completing bit, and is never high for two cycles from one match. Latency is 1 cycle.
- Overlap mode (ovl_q=1): on a match, hist and fill update normally, so bits can be reused by the next match.
- Non-overlap mode (ovl_q=0): on a match, hist is set to 0 and fill to 0, so a new match needs PAT_W fresh bits.
- hist_full = (fill==PAT_W), registered view.
- Mask all zeros: every valid bit after fill reaches PAT_W matches in overlap mode. This is legal and not trapped.
- match_cnt:
  - Increments by 1 in the cycle out is asserted, i.e. it updates on the same edge that sets out.
  - Saturates at 2^COUNT_W-1.
  - cnt_clr=1 clears it. If cnt_clr and an increment occur together, clear wins (result 0).
- State summary: FILLING (fill<PAT_W), ARMED (fill==PAT_W). Transitions:
  - FILLING→ARMED on the PAT_W-th valid bit.
  - ARMED→FILLING on cfg_load, or on a match in non-overlap mode.
  - Any state → FILLING on reset.

Decomposition:
- Package seq_det_pkg: MODE_NONOVL=1'b0 and MODE_OVL=1'b1 constants; parameter legality check helper (PAT_W range).
- Sub-module sat_counter (COUNT_W; ports: clk, rstn, clr, inc, count). It is reusable across the library's counters.
- History register, fill counter and compare logic stay in seq_pattern_det.

Test Plan:
1. PAT_W=3, pattern 110, mask 111, overlap. Stream 1,1,1,0,0 (all valid) → out pulses once, on the cycle after the 4th bit; match_cnt=1.
2. Pattern 101, overlap, stream 1,0,1,0,1 → out pulses after bits 3 and 5; match_cnt=2. Repeat with cfg_overlap=0 → one pulse after bit 3 only; match_cnt=1.
3. Pattern 110, stream 1,1,0 with in_valid=0 for 4 cycles between each bit (in toggling randomly while invalid) → exactly one pulse, after the 3rd valid bit; hist_full asserts after the 2nd... no, after the 3rd valid bit.
4. Mask 101, pattern 100. Streams 1,0,0 and 1,1,0 → both match. Stream 0,1,0 → no match.
5. COUNT_W=2, overlap, pattern 111, mask 111, ten valid 1s → match_cnt reaches 3 and holds. cnt_clr coinciding with a match → match_cnt=0 next cycle.
6. Mid-stream events after 1,1 (pattern 110):
   - rstn=0 for 1 cycle, then 0 → no match; out=0; match_cnt=0.
   - Separately, cfg_load together with in_valid=1, in=0 after 1,1 → bit dropped, no match, hist_full=0.
